// File: rtl/regfile_write_arbiter_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : regfile_pkg
// Shared register-file geometry and arbiter state encoding.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
package regfile_pkg;

  localparam int WIDTH    = 32;
  localparam int ADDR_W   = 5;
  localparam int NUM_REGS = 2 ** ADDR_W;

  typedef enum logic [0:0] {
    CLEAR = 1'b0,
    RUN   = 1'b1
  } state_t;

endpackage
`default_nettype wire

// File: rtl/regfile_write_arbiter_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : regfile_write_arbiter_if
// Two writeback request ports plus the register-file write port and status.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
interface regfile_write_arbiter_if #(
  parameter int WIDTH  = regfile_pkg::WIDTH,
  parameter int ADDR_W = regfile_pkg::ADDR_W
);
  import regfile_pkg::*;

  logic              Req0Valid;
  logic [ADDR_W-1:0] Req0Register;
  logic [WIDTH-1:0]  Req0Data;
  logic              Req0Ready;
  logic              Req1Valid;
  logic [ADDR_W-1:0] Req1Register;
  logic [WIDTH-1:0]  Req1Data;
  logic              Req1Ready;
  logic [WIDTH-1:0]  WriteData;
  logic [ADDR_W-1:0] WriteRegister;
  logic              RegWrite;
  logic              Busy;
  logic [15:0]       ConflictCount;

  modport master (
    output Req0Valid, Req0Register, Req0Data,
    output Req1Valid, Req1Register, Req1Data,
    input  Req0Ready, Req1Ready,
    input  WriteData, WriteRegister, RegWrite, Busy, ConflictCount
  );

  modport slave (
    input  Req0Valid, Req0Register, Req0Data,
    input  Req1Valid, Req1Register, Req1Data,
    output Req0Ready, Req1Ready,
    output WriteData, WriteRegister, RegWrite, Busy, ConflictCount
  );

endinterface
`default_nettype wire

// File: rtl/regfile_write_arbiter_rr_arbiter2.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : rr_arbiter2
// Two-way round-robin ready generation; owns the last-grant history bit.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module rr_arbiter2 (
  input  wire logic Clk,
  input  wire logic Reset,
  input  wire logic Accept,
  input  wire logic Valid0,
  input  wire logic Valid1,
  output logic      Ready0,
  output logic      Ready1
);

  logic r_lastGrant;
  logic w_take0;
  logic w_take1;

  // A port only loses when the other is also valid and it was served last.
  assign Ready0  = Accept && !(Valid1 && (r_lastGrant == 1'b0));
  assign Ready1  = Accept && !(Valid0 && (r_lastGrant == 1'b1));
  assign w_take0 = Valid0 && Ready0;
  assign w_take1 = Valid1 && Ready1;

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_lastGrant <= 1'b1;
    end else if (w_take0) begin
      r_lastGrant <= 1'b0;
    end else if (w_take1) begin
      r_lastGrant <= 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/regfile_write_arbiter.sv
`default_nettype none
// ---------------------------------------------------------------------------
// Module : regfile_write_arbiter
// Shares the register-file write port between two requesters after a zero sweep.
// Rev    : 1.0  initial release
// ---------------------------------------------------------------------------
module regfile_write_arbiter #(
  parameter int WIDTH          = regfile_pkg::WIDTH,
  parameter int ADDR_W         = regfile_pkg::ADDR_W,
  parameter bit CLEAR_ON_RESET = 1'b1
) (
  input  wire logic                Clk,
  input  wire logic                Reset,
  regfile_write_arbiter_if.slave   bus
);
  import regfile_pkg::*;

  localparam state_t c_resetState = CLEAR_ON_RESET ? CLEAR : RUN;

  state_t            r_state;
  logic [ADDR_W-1:0] r_clearIndex;
  logic [WIDTH-1:0]  r_writeData;
  logic [ADDR_W-1:0] r_writeRegister;
  logic              r_regWrite;
  logic [15:0]       r_conflictCount;

  logic w_run;
  logic w_ready0;
  logic w_ready1;
  logic w_accept0;
  logic w_accept1;
  logic w_conflict;

  assign w_run      = (r_state == RUN);
  assign w_accept0  = bus.Req0Valid && w_ready0;
  assign w_accept1  = bus.Req1Valid && w_ready1;
  assign w_conflict = w_run && bus.Req0Valid && bus.Req1Valid;

  rr_arbiter2 u_arb (
    .Clk    (Clk),
    .Reset  (Reset),
    .Accept (w_run),
    .Valid0 (bus.Req0Valid),
    .Valid1 (bus.Req1Valid),
    .Ready0 (w_ready0),
    .Ready1 (w_ready1)
  );

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      r_state         <= c_resetState;
      r_clearIndex    <= '0;
      r_writeData     <= '0;
      r_writeRegister <= '0;
      r_regWrite      <= 1'b0;
      r_conflictCount <= '0;
    end else if (r_state == CLEAR) begin
      r_writeRegister <= r_clearIndex;
      r_writeData     <= '0;
      r_regWrite      <= 1'b1;
      r_clearIndex    <= r_clearIndex + ADDR_W'(1);
      if (r_clearIndex == {ADDR_W{1'b1}}) begin
        r_state <= RUN;
      end
    end else begin
      // Register 0 is hardwired: the handshake completes but nothing is written.
      if (w_accept0) begin
        r_writeRegister <= bus.Req0Register;
        r_writeData     <= bus.Req0Data;
        r_regWrite      <= (bus.Req0Register != '0);
      end else if (w_accept1) begin
        r_writeRegister <= bus.Req1Register;
        r_writeData     <= bus.Req1Data;
        r_regWrite      <= (bus.Req1Register != '0);
      end else begin
        r_regWrite      <= 1'b0;
      end
      if (w_conflict && (r_conflictCount != 16'hFFFF)) begin
        r_conflictCount <= r_conflictCount + 16'd1;
      end
    end
  end

  assign bus.Req0Ready     = w_ready0;
  assign bus.Req1Ready     = w_ready1;
  assign bus.Busy          = (r_state == CLEAR);
  assign bus.WriteData     = r_writeData;
  assign bus.WriteRegister = r_writeRegister;
  assign bus.RegWrite      = r_regWrite;
  assign bus.ConflictCount = r_conflictCount;

endmodule
`default_nettype wire

// File: doc/regfile_write_arbiter.md
# regfile_write_arbiter

Shares the single write port of the 32x32 register file between two writeback requesters: port 0 (ALU writeback) and port 1 (load/multi-cycle writeback). Uses a valid/ready handshake with round-robin arbitration. After reset it sweeps all registers to zero before accepting requests. Outputs drive the register file's WriteData/WriteRegister/RegWrite inputs directly, through registered outputs.

## Interface
- WIDTH, 32, data width
- ADDR_W, 5, register address width (NUM_REGS = 2**ADDR_W)
- CLEAR_ON_RESET, 1, 1 = zero-sweep after reset; 0 = go straight to RUN
- Clk  in  1  clock, posedge
- Reset  in  1  asynchronous, active-high
- Req0Valid  in  1  port 0 write request
- Req0Register  in  ADDR_W  port 0 destination
- Req0Data  in  WIDTH  port 0 data
- Req0Ready  out  1  port 0 accepted this edge when Req0Valid && Req0Ready
- Req1Valid / Req1Register / Req1Data / Req1Ready  same as port 0, for port 1
- WriteData  out  WIDTH  to register file
- WriteRegister  out  ADDR_W  to register file
- RegWrite  out  1  to register file write enable
- Busy  out  1  high while in CLEAR
- ConflictCount  out  16  saturating count of cycles with both ports valid in RUN

## Operation
- States: CLEAR, RUN. Reset enters CLEAR (RUN if CLEAR_ON_RESET=0).
- CLEAR: on each edge, load outputs {WriteRegister=ClearIndex, WriteData=0, RegWrite=1}, then ClearIndex++. Registers 0..31 are covered in order. The edge that loads index 31 moves the state to RUN. Both Ready outputs are 0; requests are ignored and not counted.
- RUN arbitration: LastGrant is a 1-bit register, reset value 1, so port 0 wins the first tie.
  - Req0Ready = RUN && !(Req1Valid && LastGrant==0)
  - Req1Ready = RUN && !(Req0Valid && LastGrant==1)
  - At most one port is accepted per edge.
- On acceptance of port N: load WriteRegister/WriteData from port N and set LastGrant=N. RegWrite=1, except when the destination is 0. A write to register 0 is accepted (handshake completes) but RegWrite=0, so it is discarded.
- No acceptance: RegWrite=0, and WriteRegister/WriteData hold their values.
- ConflictCount increments on every RUN edge with Req0Valid && Req1Valid. It saturates at 0xFFFF and is cleared only by Reset.
- Requesters hold Valid/Register/Data stable until accepted. The block does not buffer.

## Timing
- Reset values: WriteData=0, WriteRegister=0, RegWrite=0, ConflictCount=0, ClearIndex=0, LastGrant=1, Busy=1 (0 if CLEAR_ON_RESET=0), Req0Ready=Req1Ready=0.
- Ready signals and Busy are combinational from state and Valid. All other outputs are registered.
- Clear sweep, counting edge 1 as the first edge after Reset falls:
  - edges 1..32 load registers 0..31;
  - Busy falls after edge 32;
  - the first request is accepted at edge 33;
  - the register file has written register 31 by edge 33.
- Write latency: a request accepted at edge N presents RegWrite during cycle N..N+1. The register file commits it at edge N+1, and a read of that register returns the new value after edge N+1.
- Back-to-back acceptances on consecutive edges are supported: full throughput, one write per cycle.
- Reset asserted mid-operation: outputs go immediately to their reset values, so RegWrite drops asynchronously. An in-flight output write is lost. The sweep restarts from register 0.
- Both ports valid for K edges: grants alternate 0,1,0,1... (first grant depends on LastGrant). ConflictCount advances by K.

## Structure
- Package regfile_pkg: WIDTH, ADDR_W, NUM_REGS, and the state enum {CLEAR, RUN}. Shared with the register file and its testbench.
- Sub-module rr_arbiter2: 2-way round-robin grant. Inputs are the valids and an accept strobe; outputs are the readys. It owns LastGrant.

## Test plan
- Reset released; hold both valids high → Busy=1 for 32 edges; RegWrite=1 with WriteRegister=0..31 and WriteData=0; Ready=0 throughout; ConflictCount=0; Busy=0 after edge 32.
- After sweep, Req0 writes reg 2=42, then reg 2=15 → ReadData of reg 2 is 42, then 15, each one edge after its acceptance.
- Both ports valid for 4 edges (port 0: reg 3=0xA, port 1: reg 4=0xB, each reissued after acceptance) → grant order 0,1,0,1; ConflictCount=4.
- Req1 writes reg 0=0xDEADBEEF → Req1Ready=1, RegWrite=0 next cycle; reg 0 reads back 0.
- Reset pulse during the sweep at index 17 → RegWrite=0 immediately; the next sweep starts at register 0 and takes 32 edges.
- Force 70000 conflict cycles → ConflictCount=0xFFFF and holds.
